axis_framer: RTL and testbench
==============================

AXIS_FRAMER -- requirements
Module: axis_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, width of the frame-length field.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port s_tdata, input, DATA_WIDTH, signed sample in.
REQ-006 SHALL have port s_tvalid, input, 1, upstream valid.
REQ-007 SHALL have port s_tready, output, 1, upstream ready; registered.
REQ-008 SHALL have port m_tdata, output, DATA_WIDTH, signed sample out to peak/RMS core.
REQ-009 SHALL have port m_tvalid, output, 1, downstream valid.
REQ-010 SHALL have port m_tlast, output, 1, last beat of frame.
REQ-011 SHALL have port m_tready, input, 1, downstream ready.
REQ-012 SHALL have port frame_len, input, LEN_WIDTH, beats per frame.
REQ-013 SHALL have port enable, input, 1, run request.
REQ-014 SHALL have port frame_count, output, 16, completed frames.

Function
REQ-015 SHALL accept a beat when s_tvalid && s_tready, and emit one when m_tvalid && m_tready.
REQ-016 SHALL buffer through a two-entry skid buffer (main + skid register): latency 1 cycle, full throughput, order preserved.
REQ-017 SHALL drive s_tready = !skid_full && state != IDLE && state != FLUSH, with no combinational path from m_tready.
REQ-018 SHALL hold m_tdata/m_tlast stable while m_tvalid && !m_tready.
REQ-019 SHALL keep a beat index counter, LEN_WIDTH bits, that increments on each accepted beat.
REQ-020 SHALL latch frame_len into len_q when a beat is accepted with index 0; frame_len changes mid-frame have no effect.
REQ-021 SHALL treat a latched len_q of 0 as 1, so every beat carries tlast.
REQ-022 SHALL tag an accepted beat with tlast=1 when its index == len_q-1, then reset the index to 0; the tag travels with the data through the skid registers.
REQ-023 SHALL implement states IDLE, RUN, STOP_PEND, FLUSH.
REQ-024 IDLE -> RUN when enable=1.
REQ-025 RUN -> STOP_PEND when enable=0 and index != 0.
REQ-026 RUN -> FLUSH when enable=0 and index == 0.
REQ-027 STOP_PEND SHALL keep accepting beats, then go to FLUSH on acceptance of the tlast-tagged beat.
REQ-028 FLUSH -> IDLE when both skid entries are empty; enable reasserted in FLUSH is ignored until IDLE.
REQ-029 SHALL increment frame_count when m_tvalid && m_tready && m_tlast, wrapping 0xFFFF -> 0.
REQ-030 SHALL handle simultaneous accept and emit with a full skid buffer without loss or duplication.

Reset
REQ-031 On rst, SHALL set state=IDLE, index=0, len_q=0, both skid entries empty, s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, frame_count=0.
REQ-032 Reset mid-frame SHALL discard buffered beats and the partial frame; the next frame SHALL start at index 0.

Configuration
REQ-033 With macro AXIS_FRAMER_STATS_EN defined, frame_count SHALL count per REQ-029.
REQ-034 Without AXIS_FRAMER_STATS_EN, frame_count SHALL be constant 0 and its counter SHALL not be synthesised.

Structure
REQ-035 Package axis_framer_pkg SHALL hold the state enum typedef (IDLE/RUN/STOP_PEND/FLUSH) and the FRAME_COUNT_W=16 constant.
REQ-036 The skid buffer SHALL be a sub-module, axis_skid_buf, parameterised on payload width (DATA_WIDTH+1, carrying tdata and tlast).

Verification
REQ-037 frame_len=4, enable=1, m_tready=1, samples 1..8 -> m_tlast on samples 4 and 8, frame_count=2, latency 1 cycle.
REQ-038 frame_len=3, m_tready toggled 1/0 each cycle, 30 random samples -> output sequence identical to input, tlast every 3rd beat, no drops.
REQ-039 frame_len=5, enable dropped after beat 2 -> beats 3..5 still accepted, tlast on 5, s_tready=0 afterwards, state IDLE once drained.
REQ-040 frame_len=0 -> every beat has m_tlast=1; frame_count increments per beat.
REQ-041 frame_len changed 4->2 after beat 1 of a frame -> current frame ends at beat 4, next frame has length 2.
REQ-042 rst pulsed with 2 beats buffered and m_tready=0 -> m_tvalid=0 the next cycle, frame_count=0, index restarts at 0.

Source files
------------

// File: rtl/axis_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_framer_pkg
//  Description : Shared types and constants for the AXI-Stream sample framer
//                (framer state encoding, frame counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_framer_pkg;

    // Framer control states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2,
        FLUSH     = 2'd3
    } state_t;

    // Width of the completed-frame counter
    localparam int FRAME_COUNT_W = 16;

endpackage : axis_framer_pkg
`default_nettype wire

// File: rtl/axis_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : axis_skid_buf
//  Description : Two-entry (main + skid) register slice. One cycle latency,
//                full throughput, in-order. The upstream ready is a pure
//                register output, so there is no path from out_ready to
//                in_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_buf #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             empty
);

    logic [WIDTH-1:0] main_data;
    logic             main_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;

    // Ready only while the skid register is free; a stalled main entry can
    // still absorb exactly one more beat into the skid register.
    assign in_ready  = !skid_valid;
    assign out_data  = main_data;
    assign out_valid = main_valid;
    assign empty     = !main_valid && !skid_valid;

    // Main/skid register update: refill main from skid first to keep order
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data  <= '0;
            main_valid <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else begin
            if (!main_valid || out_ready) begin
                if (skid_valid) begin
                    main_data  <= skid_data;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (in_valid && !skid_valid) begin
                    main_data  <= in_data;
                    main_valid <= 1'b1;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (in_valid && !skid_valid) begin
                // Main is stalled: park the incoming beat, main holds steady
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule : axis_skid_buf
`default_nettype wire

// File: rtl/axis_framer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_framer
//  Description : Cuts a continuous signed sample stream into frames of
//                frame_len beats, tagging the final beat with tlast, and
//                feeds the result through a skid buffer to the peak/RMS core.
//                A run/stop FSM lets a stop request finish the current frame
//                and drain the buffer before going idle.
//                Optional feature macro: AXIS_FRAMER_STATS_EN enables the
//                completed-frame counter; otherwise frame_count is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_framer
    import axis_framer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [DATA_WIDTH-1:0]    m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    input  logic                     m_tready,
    input  logic [LEN_WIDTH-1:0]     frame_len,
    input  logic                     enable,
    output logic [FRAME_COUNT_W-1:0] frame_count
);

    localparam int PAYLOAD_W = DATA_WIDTH + 1;

    state_t               state;
    logic [LEN_WIDTH-1:0] index;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] len_sel;
    logic [LEN_WIDTH-1:0] last_index;
    logic [LEN_WIDTH-1:0] index_next;
    logic                 beat_last;
    logic                 accept;
    logic                 buf_in_ready;
    logic                 buf_empty;
    logic [PAYLOAD_W-1:0] buf_out;

    // Ready depends only on registers: skid occupancy and FSM state
    assign s_tready = buf_in_ready && (state == RUN || state == STOP_PEND);
    assign accept   = s_tvalid && s_tready;

    // Frame position: first beat of a frame uses the live length, later beats
    // use the latched one; a length of 0 behaves as 1.
    always_comb begin
        len_sel    = (index == '0) ? frame_len : len_q;
        last_index = (len_sel == '0) ? '0 : len_sel - LEN_WIDTH'(1);
        beat_last  = (index == last_index);
        index_next = index;
        if (accept) begin
            index_next = beat_last ? '0 : index + LEN_WIDTH'(1);
        end
    end

    // Beat index and frame length latch
    always_ff @(posedge clk) begin
        if (rst) begin
            index <= '0;
            len_q <= '0;
        end else begin
            if (accept && index == '0) begin
                len_q <= frame_len;
            end
            index <= index_next;
        end
    end

    // Run/stop control: a stop finishes the open frame, then drains the buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) state <= RUN;
                end
                RUN: begin
                    if (!enable) state <= (index_next == '0) ? FLUSH : STOP_PEND;
                end
                STOP_PEND: begin
                    if (accept && beat_last) state <= FLUSH;
                end
                FLUSH: begin
                    if (buf_empty) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The tlast tag rides alongside the sample in the payload MSB
    axis_skid_buf #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({beat_last, s_tdata}),
        .in_valid  (accept),
        .in_ready  (buf_in_ready),
        .out_data  (buf_out),
        .out_valid (m_tvalid),
        .out_ready (m_tready),
        .empty     (buf_empty)
    );

    assign m_tdata = buf_out[DATA_WIDTH-1:0];
    assign m_tlast = buf_out[DATA_WIDTH];

`ifdef AXIS_FRAMER_STATS_EN
    logic [FRAME_COUNT_W-1:0] frame_cnt;

    // Count frames as their last beat leaves; wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (m_tvalid && m_tready && m_tlast) begin
            frame_cnt <= frame_cnt + FRAME_COUNT_W'(1);
        end
    end

    assign frame_count = frame_cnt;
`else
    assign frame_count = '0;
`endif

endmodule : axis_framer
`default_nettype wire

// File: tb/tb_axis_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_framer
//  Description : Self-checking bench for axis_framer. A queue-based model
//                assigns frame positions to accepted samples and predicts the
//                output beat sequence, tlast tags and completed-frame count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_framer;
    import axis_framer_pkg::*;

    localparam int DW = 16;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic          enable = 1'b0;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    axis_framer #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .frame_len   (frame_len),
        .enable      (enable),
        .frame_count (frame_count)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW:0]   exp_q[$];      // {tlast, data} in expected output order
    int            pos_in_frame = 0;
    int            cur_len = 1;
    int            frames_done = 0;
    logic          acc;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    int            sent;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_frames();
`ifdef AXIS_FRAMER_STATS_EN
        return 32'(16'(frames_done));
`else
        return 32'd0;
`endif
    endfunction

    // Model: a frame spans max(frame_len,1) accepted beats, length sampled at
    // the frame's first beat; the final beat of each frame carries tlast.
    task automatic model_accept(input logic [DW-1:0] d);
        logic last;
        if (pos_in_frame == 0) cur_len = (frame_len == '0) ? 1 : int'(frame_len);
        last = (pos_in_frame == cur_len - 1);
        exp_q.push_back({last, d});
        pos_in_frame = last ? 0 : pos_in_frame + 1;
    endtask

    // One clock: drive inputs, judge handshakes mid-cycle, advance past edge
    task automatic step(input logic v, input logic [DW-1:0] d, input logic mr);
        logic [DW:0] e;
        s_tvalid = v;
        s_tdata  = d;
        m_tready = mr;
        @(negedge clk);
        acc = s_tvalid && s_tready;
        chk("frame_count", 32'(frame_count), exp_frames());
        if (prev_stall) begin
            chk("hold_valid", 32'(m_tvalid), 32'd1);
            chk("hold_data", 32'(m_tdata), 32'(prev_data));
            chk("hold_last", 32'(m_tlast), 32'(prev_last));
        end
        if (m_tvalid && m_tready) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL extra_beat: observed data %0h expected no beat", m_tdata);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("m_tdata", 32'(m_tdata), 32'(e[DW-1:0]));
                chk("m_tlast", 32'(m_tlast), 32'(e[DW]));
                if (e[DW]) frames_done++;
            end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        if (acc) model_accept(d);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        for (int k = 0; k < max_cycles && exp_q.size() > 0; k++) step(1'b0, '0, 1'b1);
        chk("drained", 32'(exp_q.size()), 32'd0);
        step(1'b0, '0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));

        // frame_len=4, samples 1..8, one-cycle latency
        frame_len = 16'd4;
        enable    = 1'b1;
        step(1'b0, '0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, DW'(i), 1'b1);
            chk("s1_accept", 32'(acc), 32'd1);
            chk("s1_lat_valid", 32'(m_tvalid), 32'd1);
            chk("s1_lat_data", 32'(m_tdata), 32'(i));
        end
        drain(10);

        // frame_len=3, toggling m_tready, 30 random samples
        frame_len = 16'd3;
        sent = 0;
        for (int c = 0; c < 400 && sent < 30; c++) begin
            step(($urandom_range(0, 3) != 0), DW'($urandom), c[0]);
            if (acc) sent++;
        end
        chk("s2_sent", 32'(sent), 32'd30);
        drain(20);

        // frame_len=5, stop request after beat 2
        frame_len = 16'd5;
        sent = 0;
        for (int c = 0; c < 20 && sent < 2; c++) begin
            step(1'b1, DW'($urandom), 1'b1);
            if (acc) sent++;
        end
        enable = 1'b0;
        for (int c = 0; c < 20 && sent < 5; c++) begin
            step(1'b1, DW'($urandom), 1'b1);
            if (acc) sent++;
        end
        chk("s3_sent", 32'(sent), 32'd5);
        chk("s3_ready_after_stop", 32'(s_tready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step(1'b1, DW'($urandom), 1'b1);
            chk("s3_no_accept", 32'(acc), 32'd0);
        end
        drain(20);
        step(1'b0, '0, 1'b1);
        chk("s3_state_idle", 32'(dut.state), 32'(IDLE));

        // frame_len=0: every beat is a frame
        enable    = 1'b1;
        frame_len = 16'd0;
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, DW'($urandom), 1'b1);
            chk("s4_accept", 32'(acc), 32'd1);
        end
        drain(10);

        // length change mid-frame takes effect at the next frame
        frame_len = 16'd4;
        step(1'b1, DW'($urandom), 1'b1);
        chk("s5_first_accept", 32'(acc), 32'd1);
        frame_len = 16'd2;
        for (int i = 0; i < 7; i++) step(1'b1, DW'($urandom), 1'b1);
        drain(10);

        // reset with two beats buffered behind a stalled sink
        sent = 0;
        for (int c = 0; c < 10 && sent < 2; c++) begin
            step(1'b1, DW'($urandom), 1'b0);
            if (acc) sent++;
        end
        chk("s6_buffered", 32'(exp_q.size()), 32'd2);
        chk("s6_full_ready", 32'(s_tready), 32'd0);
        s_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        pos_in_frame = 0;
        frames_done  = 0;
        prev_stall   = 1'b0;
        chk("s6_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("s6_rst_frame_count", 32'(frame_count), 32'd0);
        chk("s6_rst_s_tready", 32'(s_tready), 32'd0);
        chk("s6_rst_state", 32'(dut.state), 32'(IDLE));
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom), 1'b1);
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_axis_framer
`default_nettype wire
